// File: rtl/udp_rx_stream.sv
// udp_rx_stream: strips the 8-byte UDP header from an IP-payload AXI-Stream
// (8/16/32/64-bit) onto a valid/ready header channel and forwards the payload
// through a single registered stage.
// Optional build macro UDP_RX_LEN_CHECK_EN: when defined, m_axis_tuser flags a
// mismatch between the received payload length and the UDP length field.
module udp_rx_stream #(
    parameter int          AXI_DATA_WIDTH = 8,
    parameter int          KEEP_WIDTH     = AXI_DATA_WIDTH / 8,
    parameter bit          PORT_FILTER    = 1'b0,
    parameter logic [15:0] FILTER_PORT    = 16'd5000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_tkeep,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    input  logic                      m_axis_trdy,
    output logic                      m_udp_hdr_tvalid,
    input  logic                      m_udp_hdr_trdy,
    output logic [15:0]               m_udp_src_port,
    output logic [15:0]               m_udp_dst_port,
    output logic [15:0]               m_udp_length,
    output logic [15:0]               m_udp_hdr_checksum,
    output logic                      o_hdr_err
);

    localparam int HDR_BEATS = 8 / KEEP_WIDTH;

    typedef enum logic [1:0] {HDR, HDR_WAIT, PAYLOAD, DROP} state_t;

    state_t                    state, state_next;
    logic [2:0]                hdr_cnt;
    logic                      hdr_last;
    logic [AXI_DATA_WIDTH-1:0] beat_be;
    logic [63:0]               hdr_next;
    logic                      hdr_accept, hdr_final, filter_reject, pay_load;

    assign hdr_accept    = (state == HDR) && s_axis_tvalid && !i_reset;
    assign hdr_final     = (hdr_cnt == 3'(HDR_BEATS - 1));
    assign filter_reject = PORT_FILTER && (hdr_next[47:32] != FILTER_PORT);
    assign pay_load      = (state == PAYLOAD) && s_axis_tvalid && s_axis_trdy;

    // Reorder the beat so the earliest byte (lane 0) lands in the MSB position.
    always_comb begin
        beat_be = '0;
        for (int l = 0; l < KEEP_WIDTH; l++)
            beat_be[AXI_DATA_WIDTH-1-8*l -: 8] = s_axis_tdata[8*l +: 8];
    end

    generate
        if (HDR_BEATS > 1) begin : g_shift
            logic [63-AXI_DATA_WIDTH:0] hdr_prev;
            assign hdr_next = {hdr_prev, beat_be};
            // Accumulate earlier header beats; the newest beat is appended at the LSB end.
            // NOTE: state is updated with non-blocking assignments so every register
            // samples the pre-edge values of its neighbours.
            always_ff @(posedge i_clk) begin
                if (i_reset)         hdr_prev <= '0;
                else if (hdr_accept) hdr_prev <= hdr_next[63-AXI_DATA_WIDTH:0];
            end
        end else begin : g_single
            assign hdr_next = beat_be;
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= HDR;
        else         state <= state_next;
    end

    // Next-state decode plus the handshake outputs that depend only on state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_next       = state;
        s_axis_trdy      = 1'b0;
        m_udp_hdr_tvalid = 1'b0;
        case (state)
            HDR: begin
                s_axis_trdy = 1'b1;
                if (s_axis_tvalid && hdr_final) begin
                    if (filter_reject) state_next = s_axis_tlast ? HDR : DROP;
                    else               state_next = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                m_udp_hdr_tvalid = 1'b1;
                if (m_udp_hdr_trdy) state_next = hdr_last ? HDR : PAYLOAD;
            end
            PAYLOAD: begin
                s_axis_trdy = m_axis_trdy || !m_axis_tvalid;
                if (s_axis_tvalid && s_axis_trdy && s_axis_tlast) state_next = HDR;
            end
            DROP: begin
                s_axis_trdy = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_next = HDR;
            end
            default: state_next = HDR;
        endcase
        if (i_reset) s_axis_trdy = 1'b0;
    end

    // Header beat counter and runt-datagram error pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hdr_cnt   <= '0;
            o_hdr_err <= 1'b0;
        end else begin
            o_hdr_err <= hdr_accept && s_axis_tlast && !hdr_final;
            if (state != HDR)
                hdr_cnt <= '0;
            else if (hdr_accept)
                hdr_cnt <= (s_axis_tlast || hdr_final) ? 3'd0 : hdr_cnt + 3'd1;
        end
    end

    // Capture header fields once a complete, accepted header has arrived.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_udp_src_port     <= '0;
            m_udp_dst_port     <= '0;
            m_udp_length       <= '0;
            m_udp_hdr_checksum <= '0;
            hdr_last           <= 1'b0;
        end else if (hdr_accept && hdr_final && !filter_reject) begin
            m_udp_src_port     <= hdr_next[63:48];
            m_udp_dst_port     <= hdr_next[47:32];
            m_udp_length       <= hdr_next[31:16];
            m_udp_hdr_checksum <= hdr_next[15:0];
            hdr_last           <= s_axis_tlast;
        end
    end

    // Single registered payload stage; holds its beat until the sink takes it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (pay_load) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_trdy) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef UDP_RX_LEN_CHECK_EN
    logic [15:0] byte_cnt;
    logic [16:0] byte_sum;
    logic [15:0] byte_sat;

    function automatic logic [16:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [16:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) cnt = cnt + 17'(keep[i]);
        return cnt;
    endfunction

    assign byte_sum = {1'b0, byte_cnt} + popcount(s_axis_tkeep);
    assign byte_sat = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

    // Count payload bytes and flag a length mismatch on the last beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt     <= '0;
            m_axis_tuser <= 1'b0;
        end else begin
            if (state == HDR)  byte_cnt <= '0;
            else if (pay_load) byte_cnt <= byte_sat;
            if (pay_load)
                m_axis_tuser <= s_axis_tlast &&
                                ((({1'b0, byte_sat} + 17'd8) != {1'b0, m_udp_length}) ||
                                 (m_udp_length < 16'd8));
        end
    end
`else
    assign m_axis_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_udp_rx_stream.sv
// Self-checking bench for udp_rx_stream at 16-bit width with the port filter on.
// A byte-level datagram model predicts header records, payload beats and runt errors.
module tb_udp_rx_stream;

    localparam int          W  = 16;
    localparam int          KW = W / 8;
    localparam logic [15:0] FP = 16'd5000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b1;
    logic [W-1:0]  s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_trdy;
    logic [W-1:0]  m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic          m_axis_trdy = 1'b0;
    logic          m_udp_hdr_tvalid;
    logic          m_udp_hdr_trdy = 1'b0;
    logic [15:0]   m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_hdr_checksum;
    logic          o_hdr_err;

    int compared = 0, mismatched = 0;
    int err_seen = 0, err_exp = 0;
    logic [63:0] exp_hdr[$];
    beat_t       exp_pay[$];

    udp_rx_stream #(.AXI_DATA_WIDTH(W), .KEEP_WIDTH(KW), .PORT_FILTER(1'b1), .FILTER_PORT(FP)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_trdy(m_axis_trdy),
        .m_udp_hdr_tvalid(m_udp_hdr_tvalid), .m_udp_hdr_trdy(m_udp_hdr_trdy),
        .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
        .m_udp_length(m_udp_length), .m_udp_hdr_checksum(m_udp_hdr_checksum),
        .o_hdr_err(o_hdr_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] keep_mask(input logic [KW-1:0] k);
        logic [W-1:0] m;
        for (int l = 0; l < KW; l++) m[8*l +: 8] = {8{k[l]}};
        return m;
    endfunction

    function automatic logic [127:0] outs();
        return 128'({s_axis_trdy, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tkeep,
                     m_axis_tdata, m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port,
                     m_udp_length, m_udp_hdr_checksum, o_hdr_err});
    endfunction

    function automatic byte_q_t mk(input logic [15:0] src, dst, len, ck, input byte_q_t pl);
        byte_q_t q;
        q = {src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], ck[15:8], ck[7:0]};
        foreach (pl[i]) q.push_back(pl[i]);
        return q;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference model: what a datagram of these bytes must produce downstream.
    task automatic model(input byte_q_t b);
        int          n, pl;
        logic [15:0] dst, len;
        beat_t       e;
        n = b.size();
        if (n < 8) begin
            err_exp++;
            return;
        end
        dst = {b[2], b[3]};
        if (dst != FP) return;
        exp_hdr.push_back({b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]});
        len = {b[4], b[5]};
        pl  = n - 8;
        for (int s = 0; s < pl; s += KW) begin
            e.data = '0;
            e.keep = '0;
            for (int l = 0; l < KW; l++)
                if (s + l < pl) begin
                    e.data[8*l +: 8] = b[8+s+l];
                    e.keep[l] = 1'b1;
                end
            e.last = (s + KW >= pl);
`ifdef UDP_RX_LEN_CHECK_EN
            e.user = e.last && (((pl + 8) != int'(len)) || (len < 16'd8));
`else
            e.user = 1'b0;
`endif
            exp_pay.push_back(e);
        end
    endtask

    // Drive one datagram lane-packed; abort_beats >= 0 stops after that many beats.
    task automatic send(input byte_q_t b, input int abort_beats);
        int            n, nb, t, idx;
        bit            acc;
        logic [W-1:0]  d;
        logic [KW-1:0] kp;
        n  = b.size();
        nb = (n + KW - 1) / KW;
        for (int k = 0; k < nb; k++) begin
            if (abort_beats >= 0 && k >= abort_beats) break;
            for (int l = 0; l < KW; l++) begin
                idx = k * KW + l;
                if (idx < n) begin
                    d[8*l +: 8] = b[idx];
                    kp[l] = 1'b1;
                end else begin
                    d[8*l +: 8] = 8'($urandom);
                    kp[l] = 1'b0;
                end
            end
            while ($urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge i_clk); #1;
            end
            s_axis_tdata  = d;
            s_axis_tkeep  = kp;
            s_axis_tlast  = (k == nb - 1);
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            t   = 0;
            while (!acc) begin
                @(negedge i_clk);
                acc = s_axis_trdy;
                @(posedge i_clk); #1;
                t++;
                if (t > 2000) begin
                    mismatched++;
                    $display("FAIL send_timeout: observed=no s_axis_trdy expected=accept within 2000 cycles");
                    $fatal(1, "input stalled");
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_hdr.size() != 0 || exp_pay.size() != 0) && t < 5000) begin
            @(posedge i_clk);
            t++;
        end
        repeat (4) @(posedge i_clk);
        #1;
        check({tag, "_hdr_left"}, exp_hdr.size(), 0);
        check({tag, "_pay_left"}, exp_pay.size(), 0);
        check({tag, "_err_count"}, err_seen, err_exp);
    endtask

    // Random sink back-pressure on both output channels.
    initial forever begin
        @(posedge i_clk); #1;
        m_axis_trdy    = 1'($urandom_range(0, 1));
        m_udp_hdr_trdy = ($urandom_range(0, 3) != 0);
    end

    // Payload channel monitor: order, content and stability while stalled.
    initial begin
        bit    stall;
        beat_t held, e;
        stall = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset) stall = 1'b0;
            else begin
                if (stall)
                    check("pay_stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                          {1'b1, held.last, held.keep, held.data});
                if (m_axis_tvalid && m_axis_trdy) begin
                    if (exp_pay.size() == 0) check("pay_unexpected", m_axis_tvalid, 1'b0);
                    else begin
                        e = exp_pay.pop_front();
                        check("pay_data", m_axis_tdata & keep_mask(m_axis_tkeep), e.data);
                        check("pay_keep", m_axis_tkeep, e.keep);
                        check("pay_last", m_axis_tlast, e.last);
                        if (e.last) check("pay_user", m_axis_tuser, e.user);
                    end
                end
                stall     = m_axis_tvalid && !m_axis_trdy;
                held.data = m_axis_tdata;
                held.keep = m_axis_tkeep;
                held.last = m_axis_tlast;
            end
        end
    end

    // Header channel monitor plus runt-error pulse counter.
    initial begin
        bit          stall;
        logic [63:0] held, obs;
        stall = 1'b0;
        forever begin
            @(negedge i_clk);
            obs = {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_hdr_checksum};
            if (i_reset) stall = 1'b0;
            else begin
                if (o_hdr_err) err_seen++;
                if (stall) check("hdr_stall_hold", {m_udp_hdr_tvalid, obs}, {1'b1, held});
                if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
                    if (exp_hdr.size() == 0) check("hdr_unexpected", m_udp_hdr_tvalid, 1'b0);
                    else check("hdr_fields", obs, exp_hdr.pop_front());
                end
                stall = m_udp_hdr_tvalid && !m_udp_hdr_trdy;
                held  = obs;
            end
        end
    end

    initial begin
        byte_q_t b, p;
        int      pl;
        logic [15:0] dst, len;

        // Power-on reset: all outputs must read zero.
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs", outs(), 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        // Basic datagram, byte-exact header and 4 payload bytes.
        b = mk(16'h1234, FP, 16'h000C, 16'hABCD, '{8'hDE, 8'hAD, 8'hBE, 8'hEF});
        model(b); send(b, -1);
        drain("basic");

        // Odd payload length: last beat carries a partial tkeep.
        b = mk(16'h0102, FP, 16'h000F, 16'h0000, rand_bytes(7));
        model(b); send(b, -1);
        drain("len_ok");
        b = mk(16'h0102, FP, 16'h0010, 16'h0000, rand_bytes(7));
        model(b); send(b, -1);
        drain("len_bad");

        // Filter: rejected datagram then accepted one back-to-back, then a rejected header-only one.
        b = mk(16'h1111, 16'd5001, 16'd18, 16'h2222, rand_bytes(10));
        model(b); send(b, -1);
        b = mk(16'h3333, FP, 16'd13, 16'h4444, rand_bytes(5));
        model(b); send(b, -1);
        b = mk(16'h5555, 16'd5001, 16'd8, 16'h6666, p);
        model(b); send(b, -1);
        drain("filter");

        // Runt: tlast on header beat 2 of 4, then a good datagram.
        b = rand_bytes(4);
        model(b); send(b, -1);
        b = mk(16'hCAFE, FP, 16'd11, 16'hBEEF, rand_bytes(3));
        model(b); send(b, -1);
        drain("runt");

        // Header-only datagram: zero-length payload.
        b = mk(16'h0A0B, FP, 16'd8, 16'h0C0D, p);
        model(b); send(b, -1);
        drain("zero_len");

        // Reset for 3 cycles in the middle of a payload.
        b = mk(16'h7777, FP, 16'd28, 16'h8888, rand_bytes(20));
        model(b); send(b, 7);
        i_reset = 1'b1;
        exp_hdr.delete();
        exp_pay.delete();
        @(posedge i_clk); @(negedge i_clk);
        check("midreset_outputs_1", outs(), 0);
        @(posedge i_clk); @(negedge i_clk);
        check("midreset_outputs_2", outs(), 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        b = mk(16'h9999, FP, 16'd14, 16'hAAAA, rand_bytes(6));
        model(b); send(b, -1);
        drain("after_reset");

        // Randomised traffic: mostly accepted, some filtered, some runts, some bad lengths.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 99) < 8) b = rand_bytes(KW * $urandom_range(1, 8 / KW - 1));
            else begin
                pl  = $urandom_range(1, 64);
                dst = ($urandom_range(0, 99) < 80) ? FP : 16'($urandom);
                case ($urandom_range(0, 9))
                    0:       len = 16'($urandom_range(0, 15));
                    1:       len = 16'($urandom);
                    default: len = 16'(pl + 8);
                endcase
                b = mk(16'($urandom), dst, len, 16'($urandom), rand_bytes(pl));
            end
            model(b); send(b, -1);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
